resample_phase_frontend: RTL
============================

Name: resample_phase_frontend

Overview:
Multi-channel input front end for the next-generation resampler. Each channel keeps a fractional phase accumulator driven by its own rate word. On each downstream output-sample demand, the channel fetches the integer number of new input samples from upstream over the pop/ack handshake and shifts them into a per-channel history window. It then signals window-ready together with the fractional phase. The downstream interpolator reads window taps through a shared random-access read port.

Parameters:
NUM_CH, 2, channel count
NUM_CH_LOG2, 1, log2(NUM_CH)
DATA_W, 24, sample width
RATE_W, 10, rate word width (unsigned fixed point)
RATE_FRAC, 6, fractional bits of rate/phase (rate 0x040 = 1.0)
DEPTH, 8, history window taps per channel
DEPTH_LOG2, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rst_ch  in  NUM_CH  synchronous per-channel clear, active-high
rate_i  in  RATE_W*NUM_CH  per-channel rate; sampled on accepted pop_i
pop_i  in  NUM_CH  downstream demand pulse, one output sample
pop_o  out  NUM_CH  upstream request pulse, one input sample
ack_i  in  NUM_CH  upstream data valid
data_i  in  DATA_W*NUM_CH  upstream samples, valid with ack_i
ack_o  out  NUM_CH  window-ready pulse
phase_o  out  RATE_FRAC*NUM_CH  fractional phase; held from ack_o until next ack_o
ovf_o  out  NUM_CH  sticky: pop_i arrived while channel busy
rd_ch_i  in  NUM_CH_LOG2  read-port channel select
rd_idx_i  in  DEPTH_LOG2  tap index; 0 = newest
rd_data_o  out  DATA_W  tap data, 1-cycle registered latency

Behaviour:
- rst low (async): all channels enter IDLE. Phase accumulators, windows, phase_o, ovf_o, pop_o, ack_o and rd_data_o are all 0.
- Per-channel FSM with states IDLE, FETCH, WAIT, DONE.
- IDLE, pop_i=1:
  - sum = {1'b0, phase} + rate (RATE_W+1 bits).
  - need = sum[RATE_W:RATE_FRAC]; phase <= sum[RATE_FRAC-1:0].
  - Next state is DONE if need==0, else FETCH.
- FETCH: pop_o=1 for exactly this one cycle; next state WAIT. An ack_i arriving in FETCH is ignored.
- WAIT, ack_i=1:
  - window shifts one tap (idx k -> k+1; idx DEPTH-1 discarded); data_i lane goes to idx 0.
  - need decrements; next state is FETCH if need is still >0, else DONE.
- WAIT, ack_i=0: stay in WAIT indefinitely; no timeout.
- DONE: ack_o=1 for one cycle and phase_o <= phase; next state IDLE.
- Latency:
  - pop_i sampled at edge k with need==0: ack_o is high in cycle k+1.
  - Each fetched sample costs at least 2 cycles.
- Outputs pop_o, ack_o and phase_o are registered.
- pop_i while not in IDLE: ignored and ovf_o[ch] set. ovf_o is cleared only by rst or rst_ch.
- ack_i in IDLE, FETCH or DONE: ignored, no window change.
- rate = 0: the channel never fetches; ack_o every pop.
- Maximum need is 2^(RATE_W-RATE_FRAC); the need counter is RATE_W-RATE_FRAC+1 bits.
- need > DEPTH is legal; only the newest DEPTH samples are retained.
- rst_ch[ch]: the channel returns to IDLE and its phase, window and ovf are cleared. pop_o/ack_o for that channel are low next cycle.
  - rst_ch beats a same-cycle pop_i or ack_i.
  - Other channels are unaffected.
- Channels run fully independently and in parallel; simultaneous events on different channels have no interaction.
- Read port:
  - rd_data_o <= window[rd_ch_i][rd_idx_i] each cycle.
  - Reading during a same-cycle shift returns the pre-shift value.
  - rd_ch_i >= NUM_CH returns 0.

Decomposition:
- Shared header resample_defs.vh: FSM state encodings and default RATE_FRAC/RATE_W constants, also for use by the interpolator.
- Sub-module resample_phase_ch: one channel's FSM, accumulator, need counter, window shift register and ovf. Generated NUM_CH times.
- The top level holds only lane slicing and the read mux.

Test Plan:
- Rate 0x040 (1.0), 4 pops on ch0, upstream acks 1 cycle after pop_o with 0x000011..0x000044 -> one pop_o per pop. phase_o=0. Taps 0..3 = 0x44, 0x33, 0x22, 0x11.
- Rate 0x021 on ch1, 4 pops -> need sequence 0,1,0,1 and phase_o 33, 2, 35, 4. pop_o pulses only on pops 2 and 4.
- Rate 0x0C0 (3.0) on ch0 while ch1 runs rate 0x040 -> ch0 gets 3 pop_o per pop, ch1 gets 1. Windows are independent, with no cross-lane corruption.
- pop_i on ch0 while it is in WAIT -> ovf_o[0]=1 and stays 1. No extra pop_o. After rst_ch[0], ovf_o[0]=0 and tap 0 reads 0.
- rst_ch[1] and pop_i[1] in the same cycle while in WAIT -> ch1 goes to IDLE, no ack_o. A late ack_i is ignored and the window stays all-zero.
- Async rst low mid-FETCH (not clock aligned) -> all outputs 0 immediately. After release, the first pop with rate 0x040 produces pop_o 2 cycles later.

Source files
------------

// File: rtl/resample_phase_frontend_pkg.sv
// Shared definitions for the resampler front end: channel FSM encoding and
// default rate/phase geometry, also consumed by the downstream interpolator.
package resample_phase_frontend_pkg;

    localparam int RATE_W_DEF    = 10;
    localparam int RATE_FRAC_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

endpackage

// File: rtl/resample_phase_ch.sv
// One resampler channel: phase accumulator, input-sample fetch sequencer,
// history window shift register and sticky overflow flag.
module resample_phase_ch
    import resample_phase_frontend_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int RATE_W    = RATE_W_DEF,
    parameter int RATE_FRAC = RATE_FRAC_DEF,
    parameter int DEPTH     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rst_ch,
    input  logic [RATE_W-1:0]              rate,
    input  logic                           pop,
    output logic                           fetch,
    input  logic                           ack,
    input  logic [DATA_W-1:0]              data,
    output logic                           ready,
    output logic [RATE_FRAC-1:0]           phase,
    output logic                           ovf,
    output logic [DEPTH-1:0][DATA_W-1:0]   window
);

    localparam int NEED_W = RATE_W - RATE_FRAC + 1;

    ch_state_e              state_q, state_d;
    logic [RATE_FRAC-1:0]   phase_q;
    logic [NEED_W-1:0]      need_q;
    logic [RATE_W:0]        sum;

    assign sum = (RATE_W+1)'(phase_q) + (RATE_W+1)'(rate);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pop) state_d = (sum[RATE_W:RATE_FRAC] == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  if (ack) state_d = (need_q > NEED_W'(1)) ? ST_FETCH : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (rst_ch) state_d = ST_IDLE;
    end

    // Handshake outputs are registered off the current state, so each pulse
    // trails its state by one cycle and the phase appears together with ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            need_q  <= '0;
            window  <= '0;
            ovf     <= 1'b0;
            fetch   <= 1'b0;
            ready   <= 1'b0;
            phase   <= '0;
        end else if (rst_ch) begin
            phase_q <= '0;
            need_q  <= '0;
            window  <= '0;
            ovf     <= 1'b0;
            fetch   <= 1'b0;
            ready   <= 1'b0;
        end else begin
            fetch <= (state_q == ST_FETCH);
            ready <= (state_q == ST_DONE);
            if (state_q == ST_DONE) phase <= phase_q;
            if (pop && state_q == ST_IDLE) begin
                phase_q <= sum[RATE_FRAC-1:0];
                need_q  <= sum[RATE_W:RATE_FRAC];
            end
            if (pop && state_q != ST_IDLE) ovf <= 1'b1;
            if (ack && state_q == ST_WAIT) begin
                window <= {window[DEPTH-2:0], data};
                need_q <= need_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/resample_phase_frontend.sv
// Multi-channel resampler front end: per-channel lane slicing around
// resample_phase_ch instances plus the shared registered window read port.
module resample_phase_frontend
    import resample_phase_frontend_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int NUM_CH_LOG2 = 1,
    parameter int DATA_W      = 24,
    parameter int RATE_W      = RATE_W_DEF,
    parameter int RATE_FRAC   = RATE_FRAC_DEF,
    parameter int DEPTH       = 8,
    parameter int DEPTH_LOG2  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           rst_ch,
    input  logic [RATE_W*NUM_CH-1:0]    rate_i,
    input  logic [NUM_CH-1:0]           pop_i,
    output logic [NUM_CH-1:0]           pop_o,
    input  logic [NUM_CH-1:0]           ack_i,
    input  logic [DATA_W*NUM_CH-1:0]    data_i,
    output logic [NUM_CH-1:0]           ack_o,
    output logic [RATE_FRAC*NUM_CH-1:0] phase_o,
    output logic [NUM_CH-1:0]           ovf_o,
    input  logic [NUM_CH_LOG2-1:0]      rd_ch_i,
    input  logic [DEPTH_LOG2-1:0]       rd_idx_i,
    output logic [DATA_W-1:0]           rd_data_o
);

    logic [NUM_CH-1:0][DEPTH-1:0][DATA_W-1:0] win;
    logic [DATA_W-1:0]                        rd_sel;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        resample_phase_ch #(
            .DATA_W    (DATA_W),
            .RATE_W    (RATE_W),
            .RATE_FRAC (RATE_FRAC),
            .DEPTH     (DEPTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .rst_ch (rst_ch[g]),
            .rate   (rate_i[g*RATE_W +: RATE_W]),
            .pop    (pop_i[g]),
            .fetch  (pop_o[g]),
            .ack    (ack_i[g]),
            .data   (data_i[g*DATA_W +: DATA_W]),
            .ready  (ack_o[g]),
            .phase  (phase_o[g*RATE_FRAC +: RATE_FRAC]),
            .ovf    (ovf_o[g]),
            .window (win[g])
        );
    end

    // Only a non-power-of-two channel count can select a missing channel.
    if (NUM_CH == (1 << NUM_CH_LOG2)) begin : g_rd_full
        assign rd_sel = win[rd_ch_i][rd_idx_i];
    end else begin : g_rd_part
        assign rd_sel = (32'(rd_ch_i) < NUM_CH) ? win[rd_ch_i][rd_idx_i] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_o <= '0;
        else      rd_data_o <= rd_sel;
    end

endmodule
